uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Parametrised UART transmitter. It integrates the frame FSM, baud divider, serializer, parity generator and output mux into one block. It supports configurable data width, odd/even/no parity, one or two stop bits, and back-to-back frames with no idle gap. It sits between the system-side data source (valid/ack handshake) and the TX pad.

Parameters:
DATA_WIDTH, 8, payload bits per frame; legal range 5..9.
CLKS_PER_BIT, 16, CLK cycles per serial bit; must be >= 1.

Ports:
CLK  input  1  system clock; all logic on rising edge.
RST  input  1  asynchronous, active-high reset.
P_DATA  input  DATA_WIDTH  parallel payload; sampled only on capture.
Data_Valid  input  1  source has a payload ready.
Parity_En  input  1  1 = insert parity bit; sampled on capture.
Parity_Type  input  1  0 = even, 1 = odd; sampled on capture.
Stop_Two  input  1  1 = two stop bits, 0 = one; sampled on capture.
TX_OUT  output  1  serial line; registered; idle high.
busy  output  1  frame in progress; registered.
Data_Ack  output  1  one-cycle pulse, high in the cycle after capture.

Behaviour:
- Reset (RST=1, asynchronous):
  - State goes to IDLE; all counters clear.
  - TX_OUT=1, busy=0, Data_Ack=0 immediately, with no CLK edge required.
  - Reset mid-frame aborts the frame with no partial stop bit. The first frame after release starts only on a new capture.
- States: IDLE, START, DATA, PARITY, STOP.
- Capture event:
  - Occurs at a rising edge where Data_Valid=1 and either (a) state=IDLE or (b) the block is in the final CLK cycle of the last stop bit.
  - On capture, P_DATA, Parity_En, Parity_Type and Stop_Two are latched into shadow registers. Input changes after capture do not affect the current frame.
  - On the capture edge: state becomes START, TX_OUT=0, busy=1, and Data_Ack=1 for exactly one cycle.
  - Data_Valid is ignored at every other time, including mid-frame. It is not queued.
- Bit timing:
  - Each bit (start, data, parity, stop) holds TX_OUT for exactly CLKS_PER_BIT cycles.
  - A baud counter runs 0..CLKS_PER_BIT-1; state or bit advances when the counter equals CLKS_PER_BIT-1.
  - With CLKS_PER_BIT=1, every bit lasts one cycle.
- Transitions:
  - START -> DATA.
  - DATA: sends bits LSB first, using bit index 0..DATA_WIDTH-1. After bit DATA_WIDTH-1 it goes to PARITY if the latched Parity_En=1, else to STOP.
  - PARITY -> STOP.
  - STOP: lasts 1 or 2 bit periods per the latched Stop_Two. It then either exits to START (capture pending) or to IDLE.
- Parity bit: XOR-reduce of the latched data. Even mode sends that value; odd mode sends its inverse.
- Frame length: CLKS_PER_BIT*(1+DATA_WIDTH+P+S) cycles, where P∈{0,1} and S∈{1,2}.
- busy:
  - Drops to 0 on the edge that enters IDLE.
  - Stays 1 continuously across back-to-back frames.
- TX_OUT in IDLE: constant 1.
- Illegal or unused state encoding: recovers to IDLE with TX_OUT=1 on the next edge.

Test Plan:
1. Single frame, 8-bit, no parity, one stop bit. DATA_WIDTH=8, CLKS_PER_BIT=4; send P_DATA=0xA5 with Parity_En=0, Stop_Two=0.
   -> TX_OUT bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles wide.
   -> busy is high for 40 cycles.
   -> Data_Ack is high for exactly 1 cycle after capture.
2. Parity on 0xA5 (four ones).
   -> Parity_Type=0 (even): parity bit = 0.
   -> Parity_Type=1 (odd): parity bit = 1.
   -> busy is high for 44 cycles in both cases.
3. Stop_Two=1 with 0x3C, no parity.
   -> Stop level of 1 lasts 8 cycles.
   -> busy is high for 44 cycles.
   -> Flipping Stop_Two mid-frame has no effect.
4. Back-to-back frames: hold Data_Valid=1, send 0x00 then 0xFF.
   -> Second start bit begins at cycle 40, with no idle cycle between frames.
   -> busy never drops between frames.
   -> Two Data_Ack pulses occur, 40 cycles apart.
5. Data_Valid pulse at cycle 12 of a frame.
   -> The pulse is ignored: no Data_Ack, and the frame contents are unchanged.
   -> Block returns to IDLE at cycle 40.
6. Reset mid-frame: assert RST asynchronously at cycle 17.
   -> TX_OUT=1 and busy=0 before the next CLK edge.
   -> After release, the line stays at 1 until a new Data_Valid arrives; the following frame is correct.

Source files
------------

// File: rtl/uart_tx_ctrl_if.sv
// Handshake and serial-line bundle between a payload source and uart_tx_ctrl.
// master = payload source, slave = transmitter.
interface uart_tx_ctrl_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  Parity_En;
   logic                  Parity_Type;
   logic                  Stop_Two;
   logic                  TX_OUT;
   logic                  busy;
   logic                  Data_Ack;

   modport master (
      output P_DATA, Data_Valid, Parity_En, Parity_Type, Stop_Two,
      input  TX_OUT, busy, Data_Ack
   );

   modport slave (
      input  P_DATA, Data_Valid, Parity_En, Parity_Type, Stop_Two,
      output TX_OUT, busy, Data_Ack
   );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: frame FSM, baud divider, serializer and parity generator in one block.
// Supports 5..9 data bits, optional even/odd parity, one or two stop bits and gapless back-to-back frames.
module uart_tx_ctrl #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic          CLK,
   input  logic          RST,
   uart_tx_ctrl_if.slave tx_bus
);
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = $clog2(DATA_WIDTH);
   localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                state_r, state_s;
   logic [BAUD_W-1:0]     baud_r, baud_s;
   logic [BIT_W-1:0]      bit_r, bit_s;
   logic                  stop_cnt_r, stop_cnt_s;
   logic [DATA_WIDTH-1:0] shift_r, shift_s;
   logic                  par_en_r, par_bit_r, stop_two_r;
   logic                  tx_r, tx_s, busy_r, ack_r;
   logic                  capture_s, bit_end_s;

   function automatic logic parity_of(input logic [DATA_WIDTH-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

   assign bit_end_s = (baud_r == BAUD_MAX);

   // Next-state, counters and serializer shift; capture also allowed in the last stop cycle
   always_comb begin
      state_s    = state_r;
      baud_s     = bit_end_s ? {BAUD_W{1'b0}} : baud_r + 1'b1;
      bit_s      = bit_r;
      stop_cnt_s = stop_cnt_r;
      shift_s    = shift_r;
      capture_s  = 1'b0;
      case (state_r)
         IDLE: begin
            baud_s = {BAUD_W{1'b0}};
            if (tx_bus.Data_Valid) begin
               capture_s = 1'b1;
               state_s   = START;
               shift_s   = tx_bus.P_DATA;
            end else begin
               state_s = IDLE;
            end
         end
         START: begin
            if (bit_end_s) begin
               state_s = DATA;
               bit_s   = {BIT_W{1'b0}};
            end else begin
               state_s = START;
            end
         end
         DATA: begin
            if (bit_end_s) begin
               if (bit_r == BIT_MAX) begin
                  state_s    = par_en_r ? PARITY : STOP;
                  stop_cnt_s = 1'b0;
               end else begin
                  bit_s   = bit_r + 1'b1;
                  shift_s = {1'b0, shift_r[DATA_WIDTH-1:1]};
               end
            end else begin
               state_s = DATA;
            end
         end
         PARITY: begin
            if (bit_end_s) begin
               state_s    = STOP;
               stop_cnt_s = 1'b0;
            end else begin
               state_s = PARITY;
            end
         end
         STOP: begin
            if (bit_end_s) begin
               if (stop_cnt_r || !stop_two_r) begin
                  if (tx_bus.Data_Valid) begin
                     capture_s = 1'b1;
                     state_s   = START;
                     shift_s   = tx_bus.P_DATA;
                  end else begin
                     state_s = IDLE;
                  end
               end else begin
                  stop_cnt_s = 1'b1;
               end
            end else begin
               state_s = STOP;
            end
         end
         default: begin
            state_s    = IDLE;
            baud_s     = {BAUD_W{1'b0}};
            bit_s      = {BIT_W{1'b0}};
            stop_cnt_s = 1'b0;
         end
      endcase
   end

   // Line level is derived from the next state so TX_OUT can be registered without lag
   always_comb begin
      tx_s = 1'b1;
      case (state_s)
         START:   tx_s = 1'b0;
         DATA:    tx_s = shift_s[0];
         PARITY:  tx_s = par_bit_r;
         default: tx_s = 1'b1;
      endcase
   end

   // State, counters, shadow frame settings and registered outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r    <= IDLE;
         baud_r     <= {BAUD_W{1'b0}};
         bit_r      <= {BIT_W{1'b0}};
         stop_cnt_r <= 1'b0;
         shift_r    <= {DATA_WIDTH{1'b0}};
         par_en_r   <= 1'b0;
         par_bit_r  <= 1'b0;
         stop_two_r <= 1'b0;
         tx_r       <= 1'b1;
         busy_r     <= 1'b0;
         ack_r      <= 1'b0;
      end else begin
         state_r    <= state_s;
         baud_r     <= baud_s;
         bit_r      <= bit_s;
         stop_cnt_r <= stop_cnt_s;
         shift_r    <= shift_s;
         tx_r       <= tx_s;
         busy_r     <= (state_s != IDLE);
         ack_r      <= capture_s;
         if (capture_s) begin
            par_en_r   <= tx_bus.Parity_En;
            par_bit_r  <= parity_of(tx_bus.P_DATA, tx_bus.Parity_Type);
            stop_two_r <= tx_bus.Stop_Two;
         end else begin
            par_en_r   <= par_en_r;
            par_bit_r  <= par_bit_r;
            stop_two_r <= stop_two_r;
         end
      end
   end

   assign tx_bus.TX_OUT   = tx_r;
   assign tx_bus.busy     = busy_r;
   assign tx_bus.Data_Ack = ack_r;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed frames plus random frames against a bit-list line model.
module tb_uart_tx_ctrl;
   localparam int DW  = 8;
   localparam int CPB = 4;

   logic CLK = 1'b0;
   logic RST;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   ack_cyc_q[$];
   bit   exp_q[$];

   uart_tx_ctrl_if #(.DATA_WIDTH(DW)) bus ();

   uart_tx_ctrl #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .tx_bus (bus)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected line level per clock after capture: start, LSB-first data, optional parity, stop bit(s)
   function automatic void build_frame(input logic [DW-1:0] d, input bit pen, input bit ptype, input bit stwo);
      bit bits[$];
      int ones;
      ones = 0;
      bits.push_back(1'b0);
      for (int i = 0; i < DW; i++) begin
         bits.push_back(d[i]);
         ones += int'(d[i]);
      end
      if (pen) bits.push_back(ptype ? (ones % 2 == 0) : (ones % 2 == 1));
      bits.push_back(1'b1);
      if (stwo) bits.push_back(1'b1);
      exp_q.delete();
      foreach (bits[i]) repeat (CPB) exp_q.push_back(bits[i]);
   endfunction

   task automatic run_frame(input logic [DW-1:0] d, input bit pen, input bit ptype, input bit stwo,
                            input bit keep_valid, input bit scramble, input int glitch_at, input int abort_at);
      int busy_cnt;
      int len;
      busy_cnt           = 0;
      bus.P_DATA         = d;
      bus.Parity_En      = pen;
      bus.Parity_Type    = ptype;
      bus.Stop_Two       = stwo;
      bus.Data_Valid     = 1'b1;
      build_frame(d, pen, ptype, stwo);
      len = exp_q.size();
      for (int k = 0; k < len; k++) begin
         @(negedge CLK);
         chk("tx_out", bus.TX_OUT, exp_q[k]);
         chk("data_ack", bus.Data_Ack, (k == 0));
         if (bus.busy === 1'b1) busy_cnt++;
         if (k == 0 && bus.Data_Ack === 1'b1) ack_cyc_q.push_back(cyc);
         if (!keep_valid) bus.Data_Valid = (k == glitch_at);
         if (scramble) begin
            bus.P_DATA      = DW'($urandom);
            bus.Parity_En   = 1'($urandom_range(0, 1));
            bus.Parity_Type = 1'($urandom_range(0, 1));
            bus.Stop_Two    = ~stwo;
         end
         if (k == abort_at) return;
      end
      chk("busy_cycles", busy_cnt, CPB * (1 + DW + int'(pen) + 1 + int'(stwo)));
      if (!keep_valid) begin
         @(negedge CLK);
         chk("end_tx_idle", bus.TX_OUT, 1);
         chk("end_busy_low", bus.busy, 0);
         chk("end_ack_low", bus.Data_Ack, 0);
      end
   endtask

   initial begin
      logic [DW-1:0] d;
      bit pen, pt, st, kv, sc;
      int gl;
      RST             = 1'b1;
      bus.P_DATA      = '0;
      bus.Data_Valid  = 1'b0;
      bus.Parity_En   = 1'b0;
      bus.Parity_Type = 1'b0;
      bus.Stop_Two    = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_tx", bus.TX_OUT, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_ack", bus.Data_Ack, 0);
      RST = 1'b0;
      repeat (4) begin
         @(negedge CLK);
         chk("idle_tx", bus.TX_OUT, 1);
         chk("idle_busy", bus.busy, 0);
      end

      // Plain frame, then even and odd parity, then two stop bits with inputs flipped mid-frame
      run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
      run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
      run_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1);
      run_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1, -1);

      // Back-to-back with Data_Valid held high
      run_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
      run_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
      chk("ack_spacing", ack_cyc_q[ack_cyc_q.size()-1] - ack_cyc_q[ack_cyc_q.size()-2], CPB * 10);

      // Mid-frame Data_Valid pulse with changed payload must be ignored
      run_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12, -1);

      // Asynchronous reset mid-frame
      run_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 17);
      #1 RST = 1'b1;
      #1;
      chk("abort_tx", bus.TX_OUT, 1);
      chk("abort_busy", bus.busy, 0);
      chk("abort_ack", bus.Data_Ack, 0);
      @(negedge CLK);
      RST = 1'b0;
      repeat (10) begin
         @(negedge CLK);
         chk("post_rst_tx", bus.TX_OUT, 1);
         chk("post_rst_busy", bus.busy, 0);
      end
      run_frame(8'h96, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1);

      // Random frames, some chained back-to-back, some with stray Data_Valid pulses
      for (int i = 0; i < 12; i++) begin
         d   = DW'($urandom);
         pen = 1'($urandom_range(0, 1));
         pt  = 1'($urandom_range(0, 1));
         st  = 1'($urandom_range(0, 1));
         kv  = (i < 11) ? 1'($urandom_range(0, 1)) : 1'b0;
         sc  = 1'($urandom_range(0, 1));
         gl  = $urandom_range(1, 30);
         run_frame(d, pen, pt, st, kv, sc, gl, -1);
         if (!kv) repeat ($urandom_range(0, 3)) @(negedge CLK);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
